// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bit levels, default target address.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEV,
    ACK_DEV,
    WADDR,
    WDATA,
    RD,
    RACK,
    IGNORE
  } i2c_state_t;

  localparam logic       BIT_ACK             = 1'b0;
  localparam logic       BIT_NACK            = 1'b1;
  localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0] metastability flop, [1] synchronized level, [2] history for edge detect
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sh   <= '1;
      sda_sh   <= '1;
      sda_s    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_sh   <= {scl_sh[1:0], scl};
      sda_sh   <= {sda_sh[1:0], sda};
      sda_s    <= sda_sh[1];
      scl_rise <=  scl_sh[1] & ~scl_sh[2];
      scl_fall <= ~scl_sh[1] &  scl_sh[2];
      start    <= ~sda_sh[1] &  sda_sh[2] & scl_sh[1];
      stop     <=  sda_sh[1] & ~sda_sh[2] & scl_sh[1];
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and a host read port.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]        DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] RESET_VAL   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_scl,
  inout  wire               io_sda,
  output logic              o_sda_oe,
  output logic              o_wr_strb,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  input  logic [ADDR_W-1:0] i_host_addr,
  output logic [DATA_W-1:0] o_host_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start;
  logic              stop;

  i2c_state_t        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        tx;
  logic [ADDR_W-1:0] ptr;
  logic              rw;
  logic              acked;
  logic              sda_oe;
  logic              busy;
  logic              wr_strb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] host_data;

  logic [7:0]        next_byte;
  logic [DATA_W-1:0] rd_byte;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (i_scl),
    .sda      (io_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign next_byte = {shreg[6:0], sda_s};
  assign rd_byte   = regs[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      acked   <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_strb <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_strb <= 1'b0;
      if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start) begin
        state   <= DEV;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DEV: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shreg[7:1] == DEVICE_ADDR) begin
                state  <= ACK_DEV;
                sda_oe <= ~BIT_ACK;
                busy   <= 1'b1;
                rw     <= shreg[0];
              end else begin
                state <= IGNORE;
              end
            end
          end
          ACK_DEV: begin
            if (scl_fall) begin
              if (rw) begin
                state   <= RD;
                tx      <= rd_byte;
                sda_oe  <= ~rd_byte[7];
                bit_cnt <= 4'd1;
              end else begin
                state   <= WADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
              end
            end
          end
          // bit_cnt 8 = drive ACK on the next fall, 9 = release it on the fall after
          WADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) ptr <= ADDR_W'(next_byte);
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe  <= ~BIT_ACK;
              bit_cnt <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          WDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                regs[ptr] <= DATA_W'(next_byte);
                wr_strb   <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= DATA_W'(next_byte);
                ptr       <= ptr + ADDR_W'(1);
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe  <= ~BIT_ACK;
              bit_cnt <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
            end
          end
          // bit_cnt counts bits already placed on the bus for the current byte
          RD: begin
            if (scl_fall) begin
              if (bit_cnt < 4'd8) begin
                sda_oe  <= ~tx[6];
                tx      <= tx << 1;
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                sda_oe <= 1'b0;
                ptr    <= ptr + ADDR_W'(1);
                acked  <= 1'b0;
                state  <= RACK;
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (sda_s == BIT_NACK) state <= IGNORE;
              else                   acked <= 1'b1;
            end else if (scl_fall && acked) begin
              acked   <= 1'b0;
              state   <= RD;
              tx      <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= 4'd1;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) host_data <= RESET_VAL;
    else     host_data <= regs[i_host_addr];
  end

  assign io_sda      = sda_oe ? 1'b0 : 1'bz;
  assign o_sda_oe    = sda_oe;
  assign o_wr_strb   = wr_strb;
  assign o_wr_addr   = wr_addr;
  assign o_wr_data   = wr_data;
  assign o_busy      = busy;
  assign o_host_data = host_data;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master driving i2c_slave_regfile against a transaction-level register model.
module tb_i2c_slave_regfile;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       sda_oe;
  logic       wr_strb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] host_addr;
  logic [7:0] host_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  model [256];
  logic [15:0] strb_q [$];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .DEVICE_ADDR (7'h50),
    .ADDR_W      (8),
    .DATA_W      (8),
    .RESET_VAL   (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_scl       (scl),
    .io_sda      (sda),
    .o_sda_oe    (sda_oe),
    .o_wr_strb   (wr_strb),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy),
    .i_host_addr (host_addr),
    .o_host_data (host_data)
  );

  always @(negedge clk) if (wr_strb) strb_q.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q;
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    b     = sda;  #Q;
    scl   = 1'b0; #Q;
  endtask

  // ack = 1 when the target pulled SDA low on the ninth clock
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(s);
      d[i] = s;
    end
    send_bit(master_ack ? 1'b0 : 1'b1);
  endtask

  task automatic host_check(input logic [7:0] a);
    host_addr = a;
    @(negedge clk);
    @(negedge clk);
    check("host_rd", host_data, model[a]);
  endtask

  task automatic wr_txn(input logic [7:0] addr, input logic [31:0] bytes, input int n);
    logic        ack;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] exp_q [$];
    bus_start();
    write_byte(8'hA0, ack); check("wr_dev_ack", ack, 1);
    check("wr_busy", busy, 1);
    write_byte(addr, ack);  check("wr_addr_ack", ack, 1);
    a = addr;
    for (int i = 0; i < n; i++) begin
      d = bytes[8*i +: 8];
      write_byte(d, ack); check("wr_data_ack", ack, 1);
      model[a] = d;
      exp_q.push_back({a, d});
      a = a + 8'd1;
    end
    bus_stop();
    settle();
    check("wr_busy_stop", busy, 0);
    check("wr_strb_count", strb_q.size(), n);
    while (exp_q.size() > 0 && strb_q.size() > 0)
      check("wr_strb", strb_q.pop_front(), exp_q.pop_front());
    strb_q.delete();
  endtask

  task automatic rd_txn(input logic [7:0] addr, input int n);
    logic       ack;
    logic [7:0] a;
    logic [7:0] d;
    bus_start();
    write_byte(8'hA0, ack); check("rd_dev_ack", ack, 1);
    write_byte(addr, ack);  check("rd_addr_ack", ack, 1);
    bus_start();
    write_byte(8'hA1, ack); check("rd_dev_r_ack", ack, 1);
    a = addr;
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, d);
      check("rd_data", d, model[a]);
      a = a + 8'd1;
    end
    check("rd_nack_release", sda_oe, 0);
    check("rd_busy", busy, 1);
    bus_stop();
    settle();
    check("rd_busy_stop", busy, 0);
    check("rd_no_strb", strb_q.size(), 0);
    strb_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ack;
    logic [7:0]  a;
    logic [31:0] bytes;
    int          n;

    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst = 1'b1; scl = 1'b1; m_low = 1'b0; host_addr = 8'h10;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_oe",      sda_oe,    0);
    check("rst_busy",    busy,      0);
    check("rst_strb",    wr_strb,   0);
    check("rst_wr_addr", wr_addr,   0);
    check("rst_wr_data", wr_data,   0);
    check("rst_host",    host_data, 0);

    // single write, then host port and random read of the same location
    wr_txn(8'h10, 32'h5A, 1);
    host_check(8'h10);
    rd_txn(8'h10, 1);

    // sequential read across the top of the address space
    wr_txn(8'hFF, 32'h2211, 2);
    rd_txn(8'hFF, 2);

    // burst write wrapping the pointer
    wr_txn(8'hFE, 32'h030201, 3);
    host_check(8'hFF);
    host_check(8'h00);

    // address mismatch
    bus_start();
    write_byte(8'hA4, ack); check("nm_dev_ack", ack, 0);
    check("nm_busy", busy, 0);
    write_byte(8'h10, ack); check("nm_addr_ack", ack, 0);
    write_byte(8'h99, ack); check("nm_data_ack", ack, 0);
    check("nm_busy2", busy, 0);
    bus_stop();
    settle();
    check("nm_no_strb", strb_q.size(), 0);
    host_check(8'h10);

    // STOP after half a data byte
    bus_start();
    write_byte(8'hA0, ack); check("ab_dev_ack", ack, 1);
    write_byte(8'h20, ack); check("ab_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    bus_stop();
    settle();
    check("ab_busy", busy, 0);
    check("ab_oe", sda_oe, 0);
    check("ab_no_strb", strb_q.size(), 0);
    host_check(8'h20);

    // randomized traffic
    for (int it = 0; it < 10; it++) begin
      a     = 8'($urandom_range(0, 255));
      n     = int'($urandom_range(1, 4));
      bytes = $urandom;
      wr_txn(a, bytes, n);
      rd_txn(a + 8'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 6; i++) host_check(8'($urandom_range(0, 255)));

    // reset in the middle of a read while the target drives a 0 bit
    wr_txn(8'h40, 32'h3C, 1);
    bus_start();
    write_byte(8'hA0, ack); check("rr_dev_ack", ack, 1);
    write_byte(8'h40, ack); check("rr_addr_ack", ack, 1);
    bus_start();
    write_byte(8'hA1, ack); check("rr_dev_r_ack", ack, 1);
    check("rr_oe_driving", sda_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rr_oe_released", sda_oe, 0);
    check("rr_busy", busy, 0);
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    bus_stop();
    settle();
    strb_q.delete();
    host_check(8'h10);
    host_check(8'h40);
    rd_txn(8'h40, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
